rv_muldiv_unit: RTL and testbench
=================================

Name: rv_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit adding the RV32M/RV64M operations to the pipelined integer core.
- Sits in the execute stage beside the integer ALU. It takes forwarded operands and holds the pipeline through a stall output while it iterates.
- Latency is configurable by trading area for bits processed per cycle.
- Handles division by zero and signed overflow on a fast path, and supports abort on flush.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- UNROLL, 1, bits retired per cycle (1, 2, 4; must divide XLEN).
- ITER, XLEN/UNROLL, derived iteration count (localparam, not overridable).

Ports:
- CLK  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  request; operation is valid in ID/EX this cycle.
- Funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Rs1  in  XLEN  forwarded operand 1 (multiplicand/dividend).
- Rs2  in  XLEN  forwarded operand 2 (multiplier/divisor).
- Flush  in  1  abort the in-flight operation (branch/jump redirect).
- Busy  out  1  iteration in progress.
- Stall  out  1  hold PC, IF/ID and ID/EX; equals (Start & IDLE & ~fast) | Busy.
- Done  out  1  one-cycle pulse; Result valid.
- Result  out  XLEN  operation result; held until the next accepted Start.

Behaviour:
- Reset (async): state IDLE, Busy=0, Done=0, Stall=0, Result=0, all internal accumulators=0.
- FSM states: IDLE, CALC, DONE.
- IDLE, Start=1, no fast path:
  - Latch magnitudes, sign flags and Funct3.
  - Go to CALC with counter=ITER-1.
- IDLE, Start=1, fast path (divide-class only):
  - Load Result directly; go to DONE.
  - Divide by zero: quotient all ones; remainder = Rs1 unmodified.
  - Signed overflow (Rs1 = most-negative, Rs2 = -1): DIV gives most-negative; REM gives 0.
- CALC: each cycle performs UNROLL shift-add (multiply) or restoring-subtract (divide) steps. At counter==0, go to DONE. Otherwise decrement the counter.
- DONE: Done=1 for exactly one cycle and Result is updated on entry. Return to IDLE. Start in DONE is ignored; the core re-presents it.
- Timing: Start sampled at edge t0. Busy=1 for cycles t0+1..t0+ITER. Done=1 at t0+ITER+1. On the fast path, Done=1 at t0+1.
- Multiply:
  - Multiply on magnitudes, 2*XLEN-bit product.
  - Negate if sign(Rs1)^sign(Rs2), considering only operands that are signed for the op (MULHSU: Rs1 only; MULHU: none).
  - MUL returns the low half; the MULH* ops return the high half.
- Divide:
  - Divide on magnitudes.
  - Quotient negated if the signs differ (signed ops).
  - Remainder takes the sign of the dividend.
  - Unsigned ops use raw operands.
- Start while Busy: ignored. The operands of the in-flight operation are held internally.
- Flush (any state except IDLE): next state IDLE; Busy and Done deasserted next cycle; Result unchanged.
- Flush and Start in the same IDLE cycle: Flush wins; the operation is not accepted.
- Reset mid-operation: immediate return to the reset values; no Done pulse.
- Width rules:
  - Internal multiply accumulator is 2*XLEN bits.
  - Divide remainder register is XLEN+1 bits, for the subtract borrow.
  - Negation is two's complement, with wrap-around (most-negative stays most-negative).

Decomposition:
- Shared package rv_muldiv_pkg holds:
  - Funct3 opcode constants (MD_MUL..MD_REMU).
  - FSM state encoding.
  - Helper function is_div(funct3) = funct3[2].
  - Helper function signed_rs1/rs2(funct3) giving the operand signedness table.
- One sub-module, rv_muldiv_step: combinational, performs UNROLL iterations of shift-add or restoring-divide per call. It is instantiated once and fed from the CALC-state registers.
- The top module holds the FSM, counter, sign-fix and fast-path logic.

Test Plan:
- MUL, Rs1=7, Rs2=0xFFFFFFFD (-3), XLEN=32, UNROLL=1 -> Result=0xFFFFFFEB; Done exactly 33 cycles after Start; Stall high cycles 0..32.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7%2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100%7 -> 2. With UNROLL=4, Done 9 cycles after Start.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5%0 -> 5, each with Done 1 cycle after Start. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same operands -> 0, with Done 1 cycle after Start.
- Flush in the 10th CALC cycle -> Busy=0 next cycle, no Done, Result keeps its previous value. An immediate new MUL 3*4 -> 12 after 33 cycles.
- Drive rst_n low mid-CALC -> all outputs 0 asynchronously. Release reset and issue a fresh DIV 9/3 -> Result 3, correct latency.

Source files
------------

// File: rtl/rv_muldiv_pkg.sv
// Shared opcode constants, FSM encoding and operand-signedness helpers
// for the RV32M/RV64M multiply/divide unit.
package rv_muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_div(input logic [2:0] funct3);
    return funct3[2];
  endfunction

  // MUL is treated as signed: the low half of the product is sign-agnostic.
  function automatic logic signed_rs1(input logic [2:0] funct3);
    case (funct3)
      MD_MULHU, MD_DIVU, MD_REMU: return 1'b0;
      default:                    return 1'b1;
    endcase
  endfunction

  function automatic logic signed_rs2(input logic [2:0] funct3);
    case (funct3)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv_muldiv_step.sv
// Combinational datapath: UNROLL shift-add multiply or restoring-divide
// steps applied to the accumulator/remainder registers in one cycle.
module rv_muldiv_step
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN:0]     rem_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [XLEN:0]     rem_o
);

  logic [2*XLEN-1:0] acc;
  logic [XLEN:0]     rem;
  logic [XLEN:0]     sum;
  logic [XLEN+1:0]   diff;
  logic              ge;

  // Multiply: LSB of acc selects an add of the multiplicand into the high
  // half, then the whole accumulator shifts right.
  // Divide: acc[XLEN-1:0] holds the dividend shifting out MSB-first while
  // quotient bits shift in at the bottom.
  always_comb begin
    acc  = acc_i;
    rem  = rem_i;
    sum  = '0;
    diff = '0;
    ge   = 1'b0;
    for (int i = 0; i < UNROLL; i++) begin
      sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_i} : '0);
      diff = {rem, acc[XLEN-1]} - {2'b00, opnd_i};
      ge   = ~diff[XLEN+1];
      if (is_div_i) begin
        rem = ge ? diff[XLEN:0] : {rem[XLEN-1:0], acc[XLEN-1]};
        acc = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ge};
      end else begin
        acc = {sum, acc[XLEN-1:1]};
      end
    end
    acc_o = acc;
    rem_o = rem;
  end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the execute stage: FSM,
// iteration counter, operand sign handling and divide fast path.
module rv_muldiv_unit
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            Start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] Rs1,
  input  logic [XLEN-1:0] Rs2,
  input  logic            Flush,
  output logic            Busy,
  output logic            Stall,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  localparam int ITER  = XLEN / UNROLL;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] fix_sign(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] fix_sign_w(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [2*XLEN-1:0] acc_nx;
  logic [XLEN:0]     rem_nx;

  rv_muldiv_step #(
    .XLEN   (XLEN),
    .UNROLL (UNROLL)
  ) u_step (
    .is_div_i (f3_q[2]),
    .opnd_i   (opnd_q),
    .acc_i    (acc_q),
    .rem_i    (rem_q),
    .acc_o    (acc_nx),
    .rem_o    (rem_nx)
  );

  logic            idle;
  logic            s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;
  logic            accept;

  assign idle     = (state_q == ST_IDLE);
  assign s1       = signed_rs1(Funct3) & Rs1[XLEN-1];
  assign s2       = signed_rs2(Funct3) & Rs2[XLEN-1];
  assign mag1     = fix_sign(s1, Rs1);
  assign mag2     = fix_sign(s2, Rs2);
  assign div_zero = (Rs2 == '0);
  assign div_ovf  = signed_rs2(Funct3) & (Rs1 == MOST_NEG) & (Rs2 == '1);
  assign fast     = is_div(Funct3) & (div_zero | div_ovf);
  assign accept   = idle & Start & ~Flush;

  // Divide by zero wins over overflow; REM* selects the remainder column.
  always_comb begin
    if (div_zero) fast_res = Funct3[1] ? Rs1 : '1;
    else          fast_res = Funct3[1] ? '0  : MOST_NEG;
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, remv, calc_res;

  assign prod = fix_sign_w(neg_q, acc_nx);
  assign quot = fix_sign(neg_q, acc_nx[XLEN-1:0]);
  assign remv = fix_sign(rneg_q, rem_nx[XLEN-1:0]);

  always_comb begin
    if (f3_q[2])               calc_res = f3_q[1] ? remv : quot;
    else if (f3_q[1:0] == 2'b00) calc_res = prod[XLEN-1:0];
    else                       calc_res = prod[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          f3_d = Funct3;
          if (fast) begin
            result_d = fast_res;
            state_d  = ST_DONE;
          end else begin
            neg_d   = s1 ^ s2;
            rneg_d  = s1;
            opnd_d  = is_div(Funct3) ? mag2 : mag1;
            acc_d   = {{XLEN{1'b0}}, (is_div(Funct3) ? mag1 : mag2)};
            rem_d   = '0;
            cnt_d   = CNT_W'(ITER - 1);
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_nx;
        rem_d = rem_nx;
        if (Flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          result_d = calc_res;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign Busy   = (state_q == ST_CALC);
  assign Done   = (state_q == ST_DONE);
  assign Stall  = (Start & idle & ~fast) | Busy;
  assign Result = result_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Bench for rv_muldiv_unit: directed and random RV32M operations on an
// UNROLL=1 and an UNROLL=4 instance, against an arithmetic reference.
module tb_rv_muldiv_unit;

  localparam logic [31:0] MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        flush = 1'b0;
  logic        busy1, stall1, done1, busy4, stall4, done4;
  logic [31:0] res1, res4;

  int n_assert = 0;
  int n_fail = 0;
  bit sel = 1'b0;
  logic [31:0] last1 = '0;

  always #5 clk = ~clk;

  rv_muldiv_unit #(.XLEN(32), .UNROLL(1)) u1 (
    .CLK(clk), .rst_n(rst_n), .Start(start1), .Funct3(funct3), .Rs1(rs1), .Rs2(rs2),
    .Flush(flush), .Busy(busy1), .Stall(stall1), .Done(done1), .Result(res1));

  rv_muldiv_unit #(.XLEN(32), .UNROLL(4)) u4 (
    .CLK(clk), .rst_n(rst_n), .Start(start4), .Funct3(funct3), .Rs1(rs1), .Rs2(rs2),
    .Flush(flush), .Busy(busy4), .Stall(stall4), .Done(done4), .Result(res4));

  logic        s_busy, s_stall, s_done;
  logic [31:0] s_res;
  assign s_busy  = sel ? busy4  : busy1;
  assign s_stall = sel ? stall4 : stall1;
  assign s_done  = sel ? done4  : done1;
  assign s_res   = sel ? res4   : res1;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) start4 = v;
    else     start1 = v;
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
        return int'(a) / int'(b);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
        return int'(a) % int'(b);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return MIN;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // One full transaction: checks Stall at issue, Busy/Stall through the
  // iterations, latency, result, single-cycle Done and result hold.
  task automatic do_op(input bit use4, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    logic [31:0] exp;
    bit fast, got, stall_ok;
    int lat_exp, k;
    exp = ref_op(f3, a, b);
    fast = f3[2] && (b == 0 || (!f3[0] && a == MIN && b == 32'hFFFF_FFFF));
    lat_exp = fast ? 1 : (use4 ? 9 : 33);
    @(negedge clk);
    sel = use4;
    funct3 = f3; rs1 = a; rs2 = b;
    drive_start(1'b1);
    #1 chk({63'd0, s_stall}, {63'd0, !fast}, {tag, "_stall_issue"});
    @(posedge clk);
    #1 drive_start(1'b0);
    k = 0; got = 0; stall_ok = 1;
    while (!got && k < 200) begin
      @(negedge clk);
      k++;
      if (s_done) got = 1;
      else if (!(s_stall && s_busy)) stall_ok = 0;
      if (k == 3 && !got) begin
        funct3 = 3'($urandom_range(0, 7)); rs1 = $urandom(); rs2 = $urandom();
        drive_start(1'b1);
      end
      if (k == 4) drive_start(1'b0);
    end
    chk({63'd0, got}, 64'd1, {tag, "_done_seen"});
    chk(64'(k), 64'(lat_exp), {tag, "_latency"});
    chk({32'd0, s_res}, {32'd0, exp}, {tag, "_result"});
    chk({63'd0, stall_ok}, 64'd1, {tag, "_busy_stall"});
    @(negedge clk);
    chk({63'd0, s_done}, 64'd0, {tag, "_done_pulse"});
    chk({32'd0, s_res}, {32'd0, exp}, {tag, "_result_hold"});
    if (!use4) last1 = exp;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit no_done;
    #3;
    chk({60'd0, busy1, stall1, done1, 1'b0}, 64'd0, "reset_ctrl_u1");
    chk({60'd0, busy4, stall4, done4, 1'b0}, 64'd0, "reset_ctrl_u4");
    chk({32'd0, res1}, 64'd0, "reset_res_u1");
    chk({32'd0, res4}, 64'd0, "reset_res_u4");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(0, 3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
    do_op(0, 3'd1, MIN, MIN, "mulh_min");
    do_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff");
    do_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff");
    do_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    do_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    do_op(0, 3'd5, 32'd100, 32'd7, "divu_100_7");
    do_op(0, 3'd7, 32'd100, 32'd7, "remu_100_7");
    do_op(0, 3'd5, 32'd5, 32'd0, "divu_by0");
    do_op(0, 3'd7, 32'd5, 32'd0, "remu_by0");
    do_op(0, 3'd4, MIN, 32'hFFFF_FFFF, "div_ovf");
    do_op(0, 3'd6, MIN, 32'hFFFF_FFFF, "rem_ovf");

    do_op(1, 3'd4, 32'hFFFF_FFF9, 32'd2, "u4_div_m7_2");
    do_op(1, 3'd6, 32'hFFFF_FFF9, 32'd2, "u4_rem_m7_2");
    do_op(1, 3'd5, 32'd100, 32'd7, "u4_divu_100_7");
    do_op(1, 3'd7, 32'd100, 32'd7, "u4_remu_100_7");
    do_op(1, 3'd1, MIN, MIN, "u4_mulh_min");

    for (int i = 0; i < 30; i++)
      do_op(0, 3'($urandom_range(0, 7)), pick(), pick(), "rnd_u1");
    for (int i = 0; i < 30; i++)
      do_op(1, 3'($urandom_range(0, 7)), pick(), pick(), "rnd_u4");

    // Flush in the 10th iteration cycle
    @(negedge clk);
    sel = 0; funct3 = 3'd0; rs1 = 32'h1234; rs2 = 32'd5; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk({63'd0, busy1}, 64'd0, "flush_busy");
    chk({63'd0, done1}, 64'd0, "flush_done");
    chk({32'd0, res1}, {32'd0, last1}, "flush_result");
    no_done = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done1 || busy1) no_done = 0;
    end
    chk({63'd0, no_done}, 64'd1, "flush_quiet");
    chk({32'd0, res1}, {32'd0, last1}, "flush_result_kept");
    do_op(0, 3'd0, 32'd3, 32'd4, "mul_after_flush");

    // Asynchronous reset in the middle of an iteration
    @(negedge clk);
    sel = 0; funct3 = 3'd5; rs1 = 32'd100; rs2 = 32'd7; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk({60'd0, busy1, stall1, done1, 1'b0}, 64'd0, "midreset_ctrl");
    chk({32'd0, res1}, 64'd0, "midreset_res");
    chk({32'd0, res4}, 64'd0, "midreset_res_u4");
    @(negedge clk);
    chk({60'd0, busy1, stall1, done1, 1'b0}, 64'd0, "midreset_held");
    rst_n = 1'b1;
    do_op(0, 3'd4, 32'd9, 32'd3, "div_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
